// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - op codes, FSM states and byte-order helper shared by mem_access_seq
// Purpose: common definitions for the memory access sequencer and its lane merge unit.
// Contents: OP_* access codes, state_t FSM encoding, byte_rev() register/memory order swap.
package mem_pkg;

  localparam logic [2:0] OP_SB = 3'd0;
  localparam logic [2:0] OP_SW = 3'd1;
  localparam logic [2:0] OP_SH = 3'd2;
  localparam logic [2:0] OP_LB = 3'd3;
  localparam logic [2:0] OP_LW = 3'd4;
  localparam logic [2:0] OP_LH = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE,
    ERR
  } state_t;

  // Memory keeps byte offset 0 in the top lane; registers keep it in the bottom byte.
  function automatic logic [31:0] byte_rev(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/lane_merge.sv
// rtl/lane_merge.sv - byte lane merge for stores and lane extract for loads
// Purpose: combinational conversion between register byte order and memory lanes.
// Ports:
//   i_op        access type (OP_*)
//   i_offset    byte offset within the word (addr[1:0])
//   i_rbuf      memory word read back (memory byte order)
//   i_wdata     store data (register byte order)
//   o_mem_wdata full word to write to memory
//   o_load_next zero-extended load result (register byte order)
module lane_merge
  import mem_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rbuf,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_mem_wdata,
  output logic [31:0] o_load_next
);

  logic [7:0] w_lane [4];
  logic [7:0] w_mrg  [4];
  logic [1:0] w_off1;

  // Lane k holds byte offset k, lane 0 being the most significant byte.
  assign w_lane[0] = i_rbuf[31:24];
  assign w_lane[1] = i_rbuf[23:16];
  assign w_lane[2] = i_rbuf[15:8];
  assign w_lane[3] = i_rbuf[7:0];

  // Only meaningful for aligned halfwords, where offset is 0 or 2.
  assign w_off1 = i_offset + 2'd1;

  always_comb begin
    for (int k = 0; k < 4; k++) w_mrg[k] = w_lane[k];
    o_load_next = 32'h0;
    case (i_op)
      OP_SB: w_mrg[i_offset] = i_wdata[7:0];
      OP_SH: begin
        w_mrg[i_offset] = i_wdata[7:0];
        w_mrg[w_off1]   = i_wdata[15:8];
      end
      OP_LB: o_load_next = {24'h0, w_lane[i_offset]};
      OP_LH: o_load_next = {16'h0, w_lane[w_off1], w_lane[i_offset]};
      OP_LW: o_load_next = byte_rev(i_rbuf);
      default: ;
    endcase
    o_mem_wdata = (i_op == OP_SW) ? byte_rev(i_wdata)
                                  : {w_mrg[0], w_mrg[1], w_mrg[2], w_mrg[3]};
  end

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - multicycle load/store sequencer in front of a word-wide memory
// Purpose: runs read / wait / merge / write for one byte, half or word access at a time.
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_req, i_op, i_addr,      request (sampled only while o_ready), access type,
//   i_wdata                   byte address, store data in register order
//   o_ready                   idle and able to accept a request
//   o_done, o_err             completion pulse, misaligned/illegal request pulse
//   o_load_data               last load result, zero-extended, register order
//   o_mem_addr, o_mem_rd,     memory word address and read strobe
//   o_mem_wr, o_mem_wdata     memory write strobe and full write word
//   i_mem_rdata               memory read data, valid MEM_LATENCY cycles after o_mem_rd
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_load_data,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wdata, r_rbuf, r_load;
  logic        w_aligned, w_req_ok, w_is_load;
  logic [31:0] w_rbuf_src, w_load_next;

  always_comb begin
    w_aligned = 1'b1;
    case (i_op)
      OP_SH, OP_LH: w_aligned = ~i_addr[0];
      OP_SW, OP_LW: w_aligned = (i_addr[1:0] == 2'b00);
      default: ;
    endcase
    w_req_ok = w_aligned && (i_op <= OP_LH);
  end

  assign w_is_load = (r_op == OP_LB) || (r_op == OP_LW) || (r_op == OP_LH);

  // On the last WAIT cycle the word is still on the bus, not yet in r_rbuf.
  assign w_rbuf_src = (r_state == WAIT) ? i_mem_rdata : r_rbuf;

  lane_merge u_lane_merge (
    .i_op        (r_op),
    .i_offset    (r_addr[1:0]),
    .i_rbuf      (w_rbuf_src),
    .i_wdata     (r_wdata),
    .o_mem_wdata (o_mem_wdata),
    .o_load_next (w_load_next)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_ready  = 1'b0;
    o_mem_rd = 1'b0;
    o_mem_wr = 1'b0;
    o_done   = 1'b0;
    o_err    = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_req) begin
          if (!w_req_ok)           w_next = ERR;
          else if (i_op == OP_SW)  w_next = WRITE;
          else                     w_next = READ;
        end
      end
      READ: begin
        o_mem_rd = 1'b1;
        w_next   = WAIT;
      end
      WAIT:  if (r_cnt == 3'd0) w_next = w_is_load ? DONE : WRITE;
      WRITE: begin
        o_mem_wr = 1'b1;
        w_next   = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      ERR: begin
        o_err  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt   <= 3'd0;
      r_op    <= OP_SB;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rbuf  <= 32'h0;
      r_load  <= 32'h0;
    end else begin
      if (r_state == IDLE && i_req && w_req_ok) begin
        r_op    <= i_op;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (r_state == READ) r_cnt <= LAT_M1;
      if (r_state == WAIT) begin
        if (r_cnt == 3'd0) begin
          r_rbuf <= i_mem_rdata;
          if (w_is_load) r_load <= w_load_next;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

  assign o_mem_addr  = {r_addr[31:2], 2'b00};
  assign o_load_data = r_load;

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - scoreboard bench for mem_access_seq at latency 1 and 3
module tb_mem_access_seq;
  import mem_pkg::*;

  typedef struct {
    logic        is_err;
    logic [31:0] ld;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
    logic [31:0] maddr;
  } exp_t;

  logic        clk;
  logic [1:0]  rst_n, req, ready, done, err, mem_rd, mem_wr;
  logic [2:0]  op_s [2];
  logic [31:0] addr_s [2], wdata_s [2], load_data [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic        mem_init;

  int   nerr = 0;
  int   nchk = 0;
  int   cyc = 0;
  exp_t q [2][$];

  int          acc [2], nrd_c [2], nwr_c [2], wrtot [2];
  int          overlap = 0;
  logic [31:0] wd_c [2], sa_c [2];
  bit          erp [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_seq #(.MEM_LATENCY(1)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n[0]), .i_req(req[0]), .i_op(op_s[0]), .i_addr(addr_s[0]),
    .i_wdata(wdata_s[0]), .o_ready(ready[0]), .o_done(done[0]), .o_err(err[0]),
    .o_load_data(load_data[0]), .o_mem_addr(mem_addr[0]), .o_mem_rd(mem_rd[0]),
    .o_mem_wr(mem_wr[0]), .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0])
  );

  mem_access_seq #(.MEM_LATENCY(3)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n[1]), .i_req(req[1]), .i_op(op_s[1]), .i_addr(addr_s[1]),
    .i_wdata(wdata_s[1]), .o_ready(ready[1]), .o_done(done[1]), .o_err(err[1]),
    .o_load_data(load_data[1]), .o_mem_addr(mem_addr[1]), .o_mem_rd(mem_rd[1]),
    .o_mem_wr(mem_wr[1]), .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1])
  );

  // Memory model: read data is only valid in the single cycle LAT cycles after mem_rd.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [16];
    int rcnt = 0;
    always @(posedge clk) begin
      if (mem_init)       mem[4] <= 32'h11223344;
      else if (mem_wr[g]) mem[mem_addr[g][5:2]] <= mem_wdata[g];
      if (mem_rd[g])      rcnt <= LAT;
      else if (rcnt != 0) rcnt <= rcnt - 1;
    end
    assign mem_rdata[g] = (rcnt == 1) ? mem[mem_addr[g][5:2]] : 32'hDEADBEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: tracks strobes per access and compares on every done/err pulse.
  initial begin : mon
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      acc[d] = 0; nrd_c[d] = 0; nwr_c[d] = 0; wrtot[d] = 0; wd_c[d] = 0; sa_c[d] = 0; erp[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (mem_wr[d]) wrtot[d]++;
        if (mem_rd[d] && mem_wr[d]) overlap++;
        if (!rst_n[d]) begin
          erp[d] = 0;
        end else begin
          if (erp[d]) begin
            chk("ready_after_err", {31'd0, ready[d]}, 32'd1);
            erp[d] = 0;
          end
          if (ready[d] && req[d]) begin
            acc[d] = cyc; nrd_c[d] = 0; nwr_c[d] = 0; wd_c[d] = 0; sa_c[d] = 0;
          end
          if (mem_rd[d]) nrd_c[d]++;
          if (mem_wr[d]) begin nwr_c[d]++; wd_c[d] = mem_wdata[d]; end
          if (mem_rd[d] || mem_wr[d]) sa_c[d] = mem_addr[d];
          if (done[d] || err[d]) begin
            if (q[d].size() == 0) begin
              nchk++; nerr++;
              $display("FAIL unexpected_completion: dut%0d done=%b err=%b with nothing pending", d, done[d], err[d]);
            end else begin
              e = q[d].pop_front();
              chk("kind", {30'd0, done[d], err[d]}, e.is_err ? 32'd1 : 32'd2);
              chk("latency", cyc - acc[d], e.lat);
              chk("rd_count", nrd_c[d], e.nrd);
              chk("wr_count", nwr_c[d], e.nwr);
              chk("load_data", load_data[d], e.ld);
              if (e.nwr != 0) chk("mem_wdata", wd_c[d], e.wd);
              if (e.nrd + e.nwr != 0) chk("mem_addr", sa_c[d], e.maddr);
              if (err[d]) erp[d] = 1;
            end
          end
        end
      end
    end
  end

  // lat < 0: issue without expecting a completion (used before an abort).
  task automatic issue(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                       input logic is_err, input logic [31:0] ld, input int lat,
                       input int nrd, input int nwr, input logic [31:0] xwd);
    exp_t e;
    int n;
    n = 0;
    while (!ready[d] && n < 50) begin @(posedge clk); #2; n++; end
    if (!ready[d]) begin
      nchk++; nerr++;
      $display("FAIL ready_timeout: dut%0d ready=%b after %0d cycles, expected 1", d, ready[d], n);
      return;
    end
    op_s[d] = o; addr_s[d] = a; wdata_s[d] = w; req[d] = 1'b1;
    if (lat >= 0) begin
      e.is_err = is_err; e.ld = ld; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.wd = xwd;
      e.maddr = {a[31:2], 2'b00};
      q[d].push_back(e);
    end
    @(posedge clk); #2;
    req[d] = 1'b0;
  endtask

  initial begin
    rst_n = 2'b00; req = 2'b00; mem_init = 1'b1;
    for (int d = 0; d < 2; d++) begin op_s[d] = 3'd0; addr_s[d] = 32'h0; wdata_s[d] = 32'h0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl0", {27'd0, ready[0], done[0], err[0], mem_rd[0], mem_wr[0]}, 32'h10);
    chk("rst_ctl1", {27'd0, ready[1], done[1], err[1], mem_rd[1], mem_wr[1]}, 32'h10);
    chk("rst_load", load_data[0], 32'h0);
    chk("rst_maddr", mem_addr[0], 32'h0);
    chk("rst_mwdata", mem_wdata[0], 32'h0);
    @(posedge clk); #2;
    rst_n = 2'b11; mem_init = 1'b0;
    @(posedge clk); #2;

    // Latency 1: d, op, addr, wdata, err, load, lat, rd, wr, mem_wdata
    issue(0, OP_LW, 32'h10, 32'h0,        0, 32'h44332211, 3, 1, 0, 32'h0);
    issue(0, OP_LB, 32'h12, 32'h0,        0, 32'h00000033, 3, 1, 0, 32'h0);
    issue(0, OP_LH, 32'h12, 32'h0,        0, 32'h00004433, 3, 1, 0, 32'h0);
    issue(0, OP_SB, 32'h11, 32'hAABBCCDD, 0, 32'h00004433, 4, 1, 1, 32'h11DD3344);
    issue(0, OP_SW, 32'h10, 32'h44332211, 0, 32'h00004433, 2, 0, 1, 32'h11223344);
    issue(0, OP_SH, 32'h12, 32'h0000BEEF, 0, 32'h00004433, 4, 1, 1, 32'h1122EFBE);
    issue(0, OP_SW, 32'h10, 32'hCAFEF00D, 0, 32'h00004433, 2, 0, 1, 32'h0DF0FECA);
    issue(0, OP_LW, 32'h10, 32'h0,        0, 32'hCAFEF00D, 3, 1, 0, 32'h0);
    issue(0, OP_LH, 32'h10, 32'h0,        0, 32'h0000F00D, 3, 1, 0, 32'h0);
    issue(0, OP_LB, 32'h13, 32'h0,        0, 32'h000000CA, 3, 1, 0, 32'h0);
    issue(0, OP_LW, 32'h13, 32'h0,        1, 32'h000000CA, 1, 0, 0, 32'h0);
    issue(0, 3'd7,  32'h10, 32'h0,        1, 32'h000000CA, 1, 0, 0, 32'h0);
    issue(0, OP_SH, 32'h11, 32'h1234,     1, 32'h000000CA, 1, 0, 0, 32'h0);
    issue(0, OP_LW, 32'h12, 32'h0,        1, 32'h000000CA, 1, 0, 0, 32'h0);
    issue(0, OP_LH, 32'h11, 32'h0,        1, 32'h000000CA, 1, 0, 0, 32'h0);
    issue(0, OP_LW, 32'h10, 32'h0,        0, 32'hCAFEF00D, 3, 1, 0, 32'h0);
    // A store request held while busy must be dropped, leaving memory untouched.
    op_s[0] = OP_SW; addr_s[0] = 32'h10; wdata_s[0] = 32'h0; req[0] = 1'b1;
    repeat (2) @(posedge clk);
    #2 req[0] = 1'b0;
    issue(0, OP_LB, 32'h10, 32'h0,        0, 32'h0000000D, 3, 1, 0, 32'h0);

    // Latency 3: abort a byte store during WAIT.
    issue(1, OP_SB, 32'h11, 32'h55,       0, 32'h0, -1, 0, 0, 32'h0);
    @(posedge clk); #2;
    rst_n[1] = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready[1]}, 32'd1);
    chk("abort_strobes", {30'd0, mem_rd[1], mem_wr[1]}, 32'd0);
    @(posedge clk); #2;
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("abort_load", load_data[1], 32'h0);
    chk("abort_ready_after", {31'd0, ready[1]}, 32'd1);
    @(posedge clk); #2;
    issue(1, OP_LW, 32'h10, 32'h0,        0, 32'h44332211, 5, 1, 0, 32'h0);
    issue(1, OP_SB, 32'h13, 32'h77,       0, 32'h44332211, 6, 1, 1, 32'h11223377);
    issue(1, OP_LH, 32'h12, 32'h0,        0, 32'h00007733, 5, 1, 0, 32'h0);

    for (int n = 0; n < 100 && (q[0].size() != 0 || q[1].size() != 0); n++) @(posedge clk);
    repeat (3) @(negedge clk);
    chk("pending0", 32'(q[0].size()), 32'd0);
    chk("pending1", 32'(q[1].size()), 32'd0);
    chk("rd_wr_overlap", overlap, 32'd0);
    chk("dut1_total_writes", wrtot[1], 32'd1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
Multicycle memory access sequencer sitting between the CPU control unit and the word-wide data memory. Accepts one load/store request (byte/half/word), runs the read, wait, merge and write sequence against memory, and returns zero-extended load data in register byte order. Sub-word stores are done as read-modify-write so memory only ever sees full-word writes. Converts between memory byte order and register byte order in both directions.

Parameters:
MEM_LATENCY, 1, cycles from the mem_rd cycle until mem_rdata is valid (legal range 1..7)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  1  request strobe, sampled only when ready=1
op  in  3  access type: OP_SB=0, OP_SW=1, OP_SH=2, OP_LB=3, OP_LW=4, OP_LH=5; 6 and 7 are illegal
addr  in  32  byte address
wdata  in  32  store data in register order
ready  out  1  high only in IDLE
done  out  1  one-cycle pulse when an access completes
err  out  1  one-cycle pulse for a misaligned address or illegal op
load_data  out  32  load result, held until the next load completes
mem_addr  out  32  word address {addr_q[31:2],2'b00}
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_wdata  out  32  full word written to memory
mem_rdata  in  32  memory read data

Behaviour:
- Reset: state=IDLE. ready=1 (combinational from state); done=0, err=0, mem_rd=0, mem_wr=0, load_data=0, mem_wdata=0, mem_addr=0.
- Byte lanes: byte offset k=addr[1:0] lives in memory lane [31-8k -: 8]. A halfword at offset h occupies lanes k=h and k=h+1, with the low byte in lane h.
- Alignment: sh/lh require addr[0]=0. sw/lw require addr[1:0]=0. Byte accesses are always aligned.
- IDLE, req=1:
  - Illegal op or misaligned address: err pulses the next cycle (in state ERR), no memory strobe, then return to IDLE. done is not asserted.
  - Otherwise latch op, addr and wdata. Next state is WRITE for sw, READ for everything else.
- READ: mem_rd=1 for exactly 1 cycle, then go to WAIT with cnt=MEM_LATENCY-1.
- WAIT: hold for MEM_LATENCY cycles. On the last WAIT cycle, capture mem_rdata into rbuf.
  - Loads go to DONE.
  - sb/sh go to WRITE.
- Load formatting:
  - lw: load_data = byte-reversed rbuf, i.e. {rbuf[7:0],rbuf[15:8],rbuf[23:16],rbuf[31:24]}.
  - lb: load_data = {24'b0, lane k}.
  - lh: load_data = {16'b0, lane h+1, lane h}.
  - load_data updates only at WAIT exit.
- Store merge:
  - sw: mem_wdata = byte-reversed wdata.
  - sb: lane k = wdata[7:0]; other lanes come from rbuf.
  - sh: lane h = wdata[7:0], lane h+1 = wdata[15:8]; the other two lanes come from rbuf.
- WRITE: mem_wr=1 for exactly 1 cycle with mem_wdata stable, then go to DONE.
- DONE: done=1 for 1 cycle, then IDLE. A new req can be accepted the cycle after DONE.
- mem_addr is valid and stable from READ (or WRITE for sw) through DONE. mem_rd and mem_wr are never high together.
- Latency from the accept cycle T:
  - sw: done at T+2.
  - loads: done at T+2+L.
  - sb/sh: done at T+3+L.
- req while ready=0 is ignored (not queued).
- Reset asserted mid-operation: immediate return to IDLE, strobes drop asynchronously, and no partial write is issued.

Decomposition:
- Shared package mem_pkg holds the op code constants OP_SB..OP_LH, the state enum type (IDLE, READ, WAIT, WRITE, DONE, ERR), and a byte-reverse function.
- One sub-module, lane_merge: combinational merge and extract of (op, offset, rbuf, wdata) into (mem_wdata, load_data_next).
- The FSM and latency counter stay in the top module.

Test Plan:
- Memory word at 0x10 = 0x11223344, lw addr 0x10 with L=1 -> mem_rd at T+1, done at T+3, load_data=0x44332211.
- Same word, lb addr 0x12 -> load_data=0x00000033. lh addr 0x12 -> load_data=0x00004433.
- sb addr 0x11, wdata 0xAABBCCDD -> one mem_wr, mem_wdata=0x11DD3344, done at T+4.
- sh addr 0x12, wdata 0x0000BEEF -> mem_wdata=0x1122EFBE. sw addr 0x10, wdata 0xCAFEF00D -> mem_wdata=0x0DF0FECA with no mem_rd, done at T+2.
- lw addr 0x13 and op=7 -> err pulse 1 cycle later, no mem_rd/mem_wr, done=0, ready again after 2 cycles.
- MEM_LATENCY=3: sb issued, reset_n pulsed low during WAIT -> no mem_wr ever, ready=1, load_data=0. A subsequent lw completes normally.
